// File: rtl/janus_bus_fifo_port.sv
// janus_bus_fifo_port
//   Memory-mapped stream I/O responder on the Janus CPU bus. CPU writes to
//   DATA push a TX FIFO that an external valid/ready consumer drains. An
//   external producer fills an RX FIFO that CPU reads of DATA pop.
//   Register map (ab[3:2]): 0 DATA, 1 STATUS {rx_count,tx_count}, 2 CTRL
//   (write bit0/bit1 flush TX/RX, reads 0), 3 error.
// Ports
//   clk_janus, rst_janus_b    clock, asynchronous active-low reset
//   cb_out[2:0], ab, dob      CPU request: [0] req, [1] wr; address; write data
//   cb_in[2:0], dib           response: [0] ack, [1] err, [2] busy; read data
//   tx_data/tx_valid/tx_ready TX stream (FIFO head out)
//   rx_data/rx_valid/rx_ready RX stream (into FIFO)
module janus_bus_fifo_port #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
  parameter int          DEPTH_LOG2 = 3
) (
  input  logic        clk_janus,
  input  logic        rst_janus_b,
  input  logic [2:0]  cb_out,
  input  logic [31:0] ab,
  input  logic [31:0] dob,
  output logic [2:0]  cb_in,
  output logic [31:0] dib,
  output logic [31:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [31:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_DROP} state_t;

  state_t        state;
  logic [31:0]   tx_mem [DEPTH];
  logic [31:0]   rx_mem [DEPTH];
  logic [PW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
  logic [PW-1:0] tx_cnt, rx_cnt;
  logic          tx_full, rx_full, rx_empty;
  logic          tx_pop, rx_push;

  logic          sel_p0;
  logic          rsp_ack_p0, rsp_err_p0;
  logic [31:0]   rsp_dat_p0;
  logic          push_p0, pop_p0;
  logic [1:0]    flush_p0;

  logic          push_p1, pop_p1;
  logic [1:0]    flush_p1;
  logic [31:0]   wdata_p1;

  logic          unused_bits;
  assign unused_bits = ^{cb_out[2], ab[1:0]};

  // FIFO status; the wrap bit separates full from empty when the low bits match
  assign tx_cnt   = tx_wr - tx_rd;
  assign rx_cnt   = rx_wr - rx_rd;
  assign tx_full  = (tx_wr[PW-1] != tx_rd[PW-1]) &&
                    (tx_wr[PW-2:0] == tx_rd[PW-2:0]);
  assign rx_full  = (rx_wr[PW-1] != rx_rd[PW-1]) &&
                    (rx_wr[PW-2:0] == rx_rd[PW-2:0]);
  assign rx_empty = (rx_wr == rx_rd);
  assign tx_valid = (tx_wr != tx_rd);
  assign rx_ready = !rx_full;
  assign tx_data  = tx_mem[tx_rd[DEPTH_LOG2-1:0]];
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_push  = rx_valid && rx_ready;

  // Stage p0: decode and response selection from the pre-edge FIFO state.
  // Between acceptance and commit only the streams move the FIFOs, and they
  // can only make room in TX or add words to RX, so the decision stays valid.
  assign sel_p0 = cb_out[0] && (ab[31:4] == BASE_ADDR[31:4]);

  always_comb begin
    rsp_ack_p0 = 1'b0;
    rsp_err_p0 = 1'b0;
    rsp_dat_p0 = '0;
    push_p0    = 1'b0;
    pop_p0     = 1'b0;
    flush_p0   = 2'b00;
    case (ab[3:2])
      2'd0: begin
        if (cb_out[1]) begin
          if (tx_full) rsp_err_p0 = 1'b1;
          else begin
            rsp_ack_p0 = 1'b1;
            push_p0    = 1'b1;
          end
        end else begin
          if (rx_empty) rsp_err_p0 = 1'b1;
          else begin
            rsp_ack_p0 = 1'b1;
            pop_p0     = 1'b1;
            rsp_dat_p0 = rx_mem[rx_rd[DEPTH_LOG2-1:0]];
          end
        end
      end
      2'd1: begin
        if (cb_out[1]) rsp_err_p0 = 1'b1;
        else begin
          rsp_ack_p0 = 1'b1;
          rsp_dat_p0 = {20'b0, 6'(rx_cnt), 6'(tx_cnt)};
        end
      end
      2'd2: begin
        rsp_ack_p0 = 1'b1;
        if (cb_out[1]) flush_p0 = dob[1:0];
      end
      default: rsp_err_p0 = 1'b1;
    endcase
  end

  // Stage p1: registered response; side-effect strobes live only in RESP
  always_ff @(posedge clk_janus or negedge rst_janus_b) begin
    if (!rst_janus_b) begin
      state    <= S_IDLE;
      cb_in    <= 3'b000;
      dib      <= '0;
      push_p1  <= 1'b0;
      pop_p1   <= 1'b0;
      flush_p1 <= 2'b00;
    end else begin
      case (state)
        S_IDLE: begin
          if (sel_p0) begin
            state    <= S_RESP;
            cb_in    <= {1'b1, rsp_err_p0, rsp_ack_p0};
            dib      <= rsp_dat_p0;
            push_p1  <= push_p0;
            pop_p1   <= pop_p0;
            flush_p1 <= flush_p0;
          end
        end
        S_RESP: begin
          state    <= S_DROP;
          cb_in    <= 3'b100;
          dib      <= '0;
          push_p1  <= 1'b0;
          pop_p1   <= 1'b0;
          flush_p1 <= 2'b00;
        end
        S_DROP: begin
          if (!cb_out[0]) begin
            state <= S_IDLE;
            cb_in <= 3'b000;
          end
        end
        default: begin
          state <= S_IDLE;
          cb_in <= 3'b000;
        end
      endcase
    end
  end

  always_ff @(posedge clk_janus) begin
    if (state == S_IDLE && sel_p0) wdata_p1 <= dob;
  end

  // TX FIFO: flush wins over any stream pop in the same cycle
  always_ff @(posedge clk_janus or negedge rst_janus_b) begin
    if (!rst_janus_b) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else if (flush_p1[0]) begin
      tx_wr <= '0;
      tx_rd <= '0;
    end else begin
      if (push_p1) tx_wr <= tx_wr + PW'(1);
      if (tx_pop)  tx_rd <= tx_rd + PW'(1);
    end
  end

  always_ff @(posedge clk_janus) begin
    if (push_p1) tx_mem[tx_wr[DEPTH_LOG2-1:0]] <= wdata_p1;
  end

  // RX FIFO: flush wins over any stream push in the same cycle
  always_ff @(posedge clk_janus or negedge rst_janus_b) begin
    if (!rst_janus_b) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else if (flush_p1[1]) begin
      rx_wr <= '0;
      rx_rd <= '0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (pop_p1)  rx_rd <= rx_rd + PW'(1);
    end
  end

  always_ff @(posedge clk_janus) begin
    if (rx_push) rx_mem[rx_wr[DEPTH_LOG2-1:0]] <= rx_data;
  end

endmodule
